mult_fu: RTL and testbench
==========================

# mult_fu

Pipelined RV32M multiply functional unit that sits directly downstream of the reservation station (`RS`). It consumes one issued instruction per cycle (operands, destination PRF index, ROB index, multiply function) and produces a tagged result for the CDB arbiter. Results wait in the output stage until the CDB grants them. Back-pressure propagates stage by stage, so bubbles collapse and no issued instruction is lost.

## Interface
Parameters:
- `STAGES`, 4, number of pipeline stages; must be 1, 2, 4 or 8 (divides 64).
- `PRF_IDX_W`, 6, physical register index width.
- `ROB_IDX_W`, 5, ROB index width.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `valid_in`  in  1  RS issues an instruction this cycle.
- `opa_in`  in  32  operand A (rs1 value).
- `opb_in`  in  32  operand B (rs2 value).
- `func_in`  in  2  `mult_func_t`.
- `dest_PRF_idx_in`  in  PRF_IDX_W  destination tag.
- `rob_idx_in`  in  ROB_IDX_W  ROB tag.
- `squash`  in  1  synchronous flush (mispredict recovery).
- `cdb_grant_in`  in  1  CDB accepts the current output this cycle.
- `ready_out`  out  1  FU accepts an issue this cycle.
- `valid_out`  out  1  result pending for the CDB.
- `result_out`  out  32  result value.
- `dest_PRF_idx_out`  out  PRF_IDX_W  tag of the result.
- `rob_idx_out`  out  ROB_IDX_W  ROB tag of the result.

## Operation
- Func encoding: MUL=00, MULH=01, MULHSU=10, MULHU=11.
- Operand extension to 64 bits:
  - opa is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - opb is sign-extended for MULH only.
- Product: low 64 bits of opa_ext × opb_ext, built across stages.
  - Stage k (0-based) adds `(opa_ext × opb_ext[k*W +: W]) << (k*W)`, where W = 64/STAGES.
  - Accumulation is modulo 2^64.
- Result: MUL returns product[31:0]; all other funcs return product[63:32].
- Each stage register holds: valid, accumulator[63:0], opa_ext, opb_ext, func, both tags.
- Advance rule, per stage s:
  - Last stage: `adv[STAGES-1] = !valid[STAGES-1] | cdb_grant_in`.
  - Other stages: `adv[s] = !valid[s] | adv[s+1]`.
  - A stage that does not advance holds its contents.
  - When it advances, it takes the upstream stage's content, or becomes invalid if upstream is invalid or itself did not advance.
- `ready_out = adv[0]`, combinational.
- Accept occurs when `valid_in & ready_out`. When `ready_out` is low, RS must hold its issue; an RS issue with `ready_out` low is ignored.
- `cdb_grant_in` when `valid_out` is low has no effect.
- `squash` clears every stage valid at the next edge and overrides any accept in the same cycle. Data registers are don't-care after a squash.
- Results leave strictly in issue order.

## Timing
- Reset values: all valids 0, all data registers 0, `valid_out` 0, `result_out` 0, both tag outputs 0. `ready_out` is 1 while out of reset.
- Latency: an instruction accepted at edge t shows `valid_out` in the cycle after edge t+STAGES-1 (STAGES cycles), provided there is no stall.
- Throughput: one result per cycle with `cdb_grant_in` held high.
- While `valid_out` is high and the grant is low, all outputs stay stable.
- Capacity: STAGES instructions in flight. `ready_out` drops only when all stages are valid and the grant is low.
- Full pipeline, grant high, and a new issue in the same cycle: the output retires and the new instruction enters stage 0 at the same edge.
- Reset mid-operation: outputs go to reset values asynchronously. Normal operation resumes on the first edge after deassertion.

## Structure
- Shared package `mult_pkg`:
  - `mult_func_t` enum.
  - `mult_stage_t` packed struct holding the stage register fields.
  - Constant `MULT_PROD_W = 64`.
- One sub-module, `mult_stage`: combinational partial-product add for one chunk, parameterised by stage index and W. The top instantiates it STAGES times with `generate`.

## Test plan
- Reset, then MUL 7 × 6 with grant tied high: `valid_out` at cycle 4, result 0x0000002A, tags match the issue.
- opa = opb = 0xFFFFFFFF, one instruction per func:
  - MUL → 0x00000001
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
  - MULHU → 0xFFFFFFFE
- Four back-to-back issues (rob 1..4) with grant high: results on four consecutive cycles in order 1..4, and `ready_out` never drops.
- Grant low with six issues attempted: `ready_out` goes low after four accepts and `valid_out` holds rob 1 stable. Raising the grant drains rob 1..4 in order; the held issues then enter.
- Squash with three instructions in flight: `valid_out` is 0 next cycle and no stale result appears. A subsequent MUL 3 × 5 returns 0x0000000F after 4 cycles.
- Assert `reset` asynchronously mid-flight: `valid_out`/`result_out` go to 0 before the next edge, and no in-flight result appears after release.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg: shared types and constants for the RV32M multiply unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_PROD_W = 64;

    typedef enum logic [1:0] {
        MULT_MUL    = 2'b00,
        MULT_MULH   = 2'b01,
        MULT_MULHSU = 2'b10,
        MULT_MULHU  = 2'b11
    } mult_func_t;

    // Tags are parameter-sized, so they live beside this struct in the top.
    typedef struct packed {
        logic                   valid;
        logic [MULT_PROD_W-1:0] acc;
        logic [MULT_PROD_W-1:0] opa;
        logic [MULT_PROD_W-1:0] opb;
        mult_func_t             func;
    } mult_stage_t;

endpackage

`default_nettype wire

// File: rtl/mult_stage.sv
// ============================================================================
// mult_stage: adds one shifted W-bit partial product into the accumulator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_stage
    import mult_pkg::*;
#(
    parameter int STAGE_IDX = 0,
    parameter int W         = 16
) (
    input  logic [MULT_PROD_W-1:0] acc_i,
    input  logic [MULT_PROD_W-1:0] opa_i,
    input  logic [W-1:0]           chunk_i,
    output logic [MULT_PROD_W-1:0] acc_o
);

    localparam int c_SHIFT = STAGE_IDX * W;

    logic [MULT_PROD_W-1:0] w_pp;

    assign w_pp  = opa_i * MULT_PROD_W'(chunk_i);
    assign acc_o = acc_i + (w_pp << c_SHIFT);

endmodule

`default_nettype wire

// File: rtl/mult_fu.sv
// ============================================================================
// mult_fu: pipelined RV32M multiplier with per-stage back-pressure to the CDB.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_fu
    import mult_pkg::*;
#(
    parameter int STAGES    = 4,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [31:0]          opa_in,
    input  logic [31:0]          opb_in,
    input  logic [1:0]           func_in,
    input  logic [PRF_IDX_W-1:0] dest_PRF_idx_in,
    input  logic [ROB_IDX_W-1:0] rob_idx_in,
    input  logic                 squash,
    input  logic                 cdb_grant_in,
    output logic                 ready_out,
    output logic                 valid_out,
    output logic [31:0]          result_out,
    output logic [PRF_IDX_W-1:0] dest_PRF_idx_out,
    output logic [ROB_IDX_W-1:0] rob_idx_out
);

    localparam int c_W = MULT_PROD_W / STAGES;

    mult_stage_t            stage_q [STAGES];
    mult_stage_t            stage_d [STAGES];
    logic [PRF_IDX_W-1:0]   prf_q   [STAGES];
    logic [PRF_IDX_W-1:0]   prf_d   [STAGES];
    logic [ROB_IDX_W-1:0]   rob_q   [STAGES];
    logic [ROB_IDX_W-1:0]   rob_d   [STAGES];

    mult_stage_t            w_src     [STAGES];
    logic [PRF_IDX_W-1:0]   w_prf_src [STAGES];
    logic [ROB_IDX_W-1:0]   w_rob_src [STAGES];
    logic [MULT_PROD_W-1:0] w_sum     [STAGES];
    logic [STAGES-1:0]      w_valid;
    logic [STAGES-1:0]      w_adv;
    mult_func_t             w_func_in;
    logic [MULT_PROD_W-1:0] w_opa_ext;
    logic [MULT_PROD_W-1:0] w_opb_ext;
    mult_stage_t            w_last;

    assign w_func_in = mult_func_t'(func_in);

    always_comb begin
        w_opa_ext = {32'b0, opa_in};
        w_opb_ext = {32'b0, opb_in};
        if (w_func_in == MULT_MULH || w_func_in == MULT_MULHSU) begin
            w_opa_ext = {{32{opa_in[31]}}, opa_in};
        end
        if (w_func_in == MULT_MULH) begin
            w_opb_ext = {{32{opb_in[31]}}, opb_in};
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            w_valid[s] = stage_q[s].valid;
        end
    end

    // A stage may move when it or any stage below it holds a bubble, or the CDB drains.
    for (genvar s = 0; s < STAGES; s++) begin : g_adv
        assign w_adv[s] = cdb_grant_in | ~(&w_valid[STAGES-1:s]);
    end

    always_comb begin
        w_src[0].valid = valid_in;
        w_src[0].acc   = '0;
        w_src[0].opa   = w_opa_ext;
        w_src[0].opb   = w_opb_ext;
        w_src[0].func  = w_func_in;
        w_prf_src[0]   = dest_PRF_idx_in;
        w_rob_src[0]   = rob_idx_in;
        for (int s = 1; s < STAGES; s++) begin
            w_src[s]     = stage_q[s-1];
            w_prf_src[s] = prf_q[s-1];
            w_rob_src[s] = rob_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        mult_stage #(
            .STAGE_IDX (s),
            .W         (c_W)
        ) u_stage (
            .acc_i   (w_src[s].acc),
            .opa_i   (w_src[s].opa),
            .chunk_i (w_src[s].opb[s*c_W +: c_W]),
            .acc_o   (w_sum[s])
        );
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s] = stage_q[s];
            prf_d[s]   = prf_q[s];
            rob_d[s]   = rob_q[s];
            if (w_adv[s]) begin
                stage_d[s]     = w_src[s];
                stage_d[s].acc = w_sum[s];
                prf_d[s]       = w_prf_src[s];
                rob_d[s]       = w_rob_src[s];
            end
            if (squash) begin
                stage_d[s].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
                prf_q[s]   <= '0;
                rob_q[s]   <= '0;
            end
        end else begin
            stage_q <= stage_d;
            prf_q   <= prf_d;
            rob_q   <= rob_d;
        end
    end

    assign w_last           = stage_q[STAGES-1];
    assign ready_out        = w_adv[0];
    assign valid_out        = w_last.valid;
    assign result_out       = (w_last.func == MULT_MUL) ? w_last.acc[31:0] : w_last.acc[63:32];
    assign dest_PRF_idx_out = prf_q[STAGES-1];
    assign rob_idx_out      = rob_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_mult_fu.sv
// ============================================================================
// tb_mult_fu: directed and randomized checks of mult_fu against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_fu;

    localparam int STAGES = 4;
    localparam int PW     = 6;
    localparam int RW     = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [31:0]   opa_in;
    logic [31:0]   opb_in;
    logic [1:0]    func_in;
    logic [PW-1:0] dest_PRF_idx_in;
    logic [RW-1:0] rob_idx_in;
    logic          squash;
    logic          cdb_grant_in;
    logic          ready_out;
    logic          valid_out;
    logic [31:0]   result_out;
    logic [PW-1:0] dest_PRF_idx_out;
    logic [RW-1:0] rob_idx_out;

    always #5 clock = ~clock;

    mult_fu #(
        .STAGES    (STAGES),
        .PRF_IDX_W (PW),
        .ROB_IDX_W (RW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .valid_in         (valid_in),
        .opa_in           (opa_in),
        .opb_in           (opb_in),
        .func_in          (func_in),
        .dest_PRF_idx_in  (dest_PRF_idx_in),
        .rob_idx_in       (rob_idx_in),
        .squash           (squash),
        .cdb_grant_in     (cdb_grant_in),
        .ready_out        (ready_out),
        .valid_out        (valid_out),
        .result_out       (result_out),
        .dest_PRF_idx_out (dest_PRF_idx_out),
        .rob_idx_out      (rob_idx_out)
    );

    typedef struct {
        logic [31:0]   res;
        logic [PW-1:0] prf;
        logic [RW-1:0] rob;
    } exp_t;

    exp_t          model_q[$];
    logic [31:0]   log_res[$];
    logic [RW-1:0] log_rob[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (f == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: in-order queue of accepted instructions; one occupied stage per entry.
    always @(negedge clock) begin
        if (reset) begin
            model_q.delete();
        end else begin
            chk("ready_out", 64'(ready_out), 64'(!(model_q.size() == STAGES && !cdb_grant_in)));
            if (model_q.size() == STAGES) chk("valid_out_full", 64'(valid_out), 64'd1);
            if (valid_out) begin
                chk("result_pending", 64'(model_q.size() != 0), 64'd1);
                if (model_q.size() != 0) begin
                    chk("result_out", 64'(result_out), 64'(model_q[0].res));
                    chk("dest_PRF_idx_out", 64'(dest_PRF_idx_out), 64'(model_q[0].prf));
                    chk("rob_idx_out", 64'(rob_idx_out), 64'(model_q[0].rob));
                end
                if (cdb_grant_in) begin
                    log_res.push_back(result_out);
                    log_rob.push_back(rob_idx_out);
                    if (model_q.size() != 0) void'(model_q.pop_front());
                end
            end
            if (squash) begin
                model_q.delete();
            end else if (valid_in && ready_out) begin
                model_q.push_back('{ref_mul(func_in, opa_in, opb_in), dest_PRF_idx_in, rob_idx_in});
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [RW-1:0] r, input logic [PW-1:0] p);
        bit ok = 1'b0;
        valid_in = 1'b1; func_in = f; opa_in = a; opb_in = b;
        rob_idx_in = r; dest_PRF_idx_in = p;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = ready_out && !squash;
            @(posedge clock);
            #1;
        end
        valid_in = 1'b0;
        chk("issue_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_res(output int n, output logic [31:0] res,
                            output logic [RW-1:0] rob, output logic [PW-1:0] prf);
        bit got = 1'b0;
        n = 0; res = '0; rob = '0; prf = '0;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clock);
            if (valid_out && cdb_grant_in) begin
                got = 1'b1; n = i; res = result_out; rob = rob_idx_out; prf = dest_PRF_idx_out;
            end
            @(posedge clock);
            #1;
        end
        chk("result_arrives", 64'(got), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 4)
            0:       return $urandom;
            1:       return 32'h0;
            2:       return 32'hFFFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    int            n;
    logic [31:0]   res;
    logic [RW-1:0] rob;
    logic [PW-1:0] prf;
    logic [31:0]   func_exp [4];
    bit            acc;

    initial begin
        reset = 1'b1; valid_in = 1'b0; opa_in = '0; opb_in = '0; func_in = '0;
        dest_PRF_idx_in = '0; rob_idx_in = '0; squash = 1'b0; cdb_grant_in = 1'b0;
        cycles(2);
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_result_out", 64'(result_out), 64'd0);
        chk("rst_prf_out", 64'(dest_PRF_idx_out), 64'd0);
        chk("rst_rob_out", 64'(rob_idx_out), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_out", 64'(ready_out), 64'd1);
        @(posedge clock); #1;

        // MUL 7 x 6, grant tied high
        cdb_grant_in = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 5'd3, 6'd9);
        wait_res(n, res, rob, prf);
        chk("mul_latency", 64'(n), 64'(STAGES));
        chk("mul_7x6", 64'(res), 64'h2A);
        chk("mul_rob", 64'(rob), 64'd3);
        chk("mul_prf", 64'(prf), 64'd9);

        // All four funcs with all-ones operands, issued back to back
        func_exp = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 4; i++) issue(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i + 1), 6'(i + 20));
        for (int i = 0; i < 4; i++) begin
            wait_res(n, res, rob, prf);
            chk("b2b_spacing", 64'(n), 64'd1);
            chk("func_ones", 64'(res), 64'(func_exp[i]));
            chk("b2b_order", 64'(rob), 64'(i + 1));
        end

        // Grant low: four fill the pipe, the fifth is held back
        cdb_grant_in = 1'b0;
        for (int i = 1; i <= 4; i++) issue(2'b00, 32'(i), 32'd10, 5'(i), 6'(i));
        valid_in = 1'b1; func_in = 2'b00; opa_in = 32'd5; opb_in = 32'd10;
        rob_idx_in = 5'd5; dest_PRF_idx_in = 6'd5;
        @(negedge clock);
        chk("full_ready_low", 64'(ready_out), 64'd0);
        chk("full_valid_out", 64'(valid_out), 64'd1);
        chk("full_head_rob", 64'(rob_idx_out), 64'd1);
        chk("full_head_res", 64'(result_out), 64'd10);
        @(posedge clock); #1;
        @(negedge clock);
        chk("stall_stable_rob", 64'(rob_idx_out), 64'd1);
        chk("stall_stable_res", 64'(result_out), 64'd10);
        @(posedge clock); #1;
        log_res.delete(); log_rob.delete();
        cdb_grant_in = 1'b1;
        issue(2'b00, 32'd5, 32'd10, 5'd5, 6'd5);
        issue(2'b00, 32'd6, 32'd10, 5'd6, 6'd6);
        cycles(8);
        chk("drain_count", 64'(log_rob.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_rob.size(); i++) begin
            chk("drain_order", 64'(log_rob[i]), 64'(i + 1));
            chk("drain_res", 64'(log_res[i]), 64'((i + 1) * 10));
        end

        // Squash with three in flight
        log_res.delete(); log_rob.delete();
        for (int i = 0; i < 3; i++) issue(2'b00, 32'd2, 32'd2, 5'(10 + i), 6'(10 + i));
        squash = 1'b1;
        cycles(1);
        squash = 1'b0;
        @(negedge clock);
        chk("squash_valid_out", 64'(valid_out), 64'd0);
        @(posedge clock); #1;
        cycles(6);
        chk("squash_no_stale", 64'(log_rob.size()), 64'd0);
        issue(2'b00, 32'd3, 32'd5, 5'd13, 6'd13);
        wait_res(n, res, rob, prf);
        chk("post_squash_latency", 64'(n), 64'(STAGES));
        chk("post_squash_3x5", 64'(res), 64'hF);
        chk("post_squash_rob", 64'(rob), 64'd13);

        // Asynchronous reset while results are pending
        cdb_grant_in = 1'b0;
        log_res.delete(); log_rob.delete();
        issue(2'b00, 32'd9, 32'd9, 5'd20, 6'd20);
        issue(2'b00, 32'd5, 32'd5, 5'd21, 6'd21);
        for (int i = 0; i < 20 && !valid_out; i++) @(negedge clock);
        @(posedge clock); #1;
        chk("pre_reset_valid", 64'(valid_out), 64'd1);
        chk("pre_reset_res", 64'(result_out), 64'h51);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(valid_out), 64'd0);
        chk("async_rst_res", 64'(result_out), 64'd0);
        chk("async_rst_rob", 64'(rob_idx_out), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        cdb_grant_in = 1'b1;
        cycles(8);
        chk("no_result_after_reset", 64'(log_rob.size()), 64'd0);

        // Randomized traffic; the model process checks every cycle
        acc = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            cdb_grant_in = (c % 64 < 12) ? 1'b0 : (($urandom % 4) != 0);
            squash = ($urandom % 40) == 0;
            if (!valid_in || acc) begin
                valid_in = ($urandom % 3) != 0;
                func_in = 2'($urandom);
                opa_in = pick();
                opb_in = pick();
                rob_idx_in = RW'($urandom);
                dest_PRF_idx_in = PW'($urandom);
            end
            @(negedge clock);
            acc = valid_in && ready_out && !squash;
            @(posedge clock); #1;
        end
        valid_in = 1'b0; squash = 1'b0; cdb_grant_in = 1'b1;
        cycles(10);
        chk("drain_empty", 64'(model_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
